// File: rtl/game_pkg.sv
// Shared types for the parametrised game counter: mode encoding and winner report.
package game_pkg;

  typedef enum logic [2:0] {
    UP1   = 3'd0,
    UP2   = 3'd1,
    DN1   = 3'd2,
    DN2   = 3'd3,
    UPS   = 3'd4,
    DNS   = 3'd5,
    HOLD0 = 3'd6,
    HOLD1 = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    WHO_NONE   = 2'd0,
    WHO_LOSER  = 2'd1,
    WHO_WINNER = 2'd2
  } who_e;

endpackage : game_pkg

// File: rtl/game_score_counter.sv
// Event score counter; hit_limit flags the edge on which the score will reach the limit.
module game_score_counter #(
  parameter int unsigned SCORE_W        = 4,
  parameter int unsigned GAMEOVER_LIMIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] score,
  output logic               hit_limit
);

  localparam logic [SCORE_W-1:0] LIMIT_V = SCORE_W'(GAMEOVER_LIMIT);

  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;

  assign score_d   = score_q + SCORE_W'(1);
  assign hit_limit = inc && (score_d == LIMIT_V);
  assign score     = score_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
    end else if (clr) begin
      score_q <= '0;
    end else if (inc) begin
      score_q <= score_d;
    end
  end

endmodule : game_score_counter

// File: rtl/game_state_param.sv
// Multi-mode wrapping game counter with win/lose scoring and a sticky game-over freeze.
module game_state_param
  import game_pkg::*;
#(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned SCORE_W        = 4,
  parameter int unsigned GAMEOVER_LIMIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         control,
  input  logic [WIDTH-1:0]   i_value,
  input  logic [WIDTH-1:0]   i_step,
  input  logic               INIT,
  output logic [WIDTH-1:0]   count,
  output logic               win,
  output logic               los,
  output logic [SCORE_W-1:0] win_count,
  output logic [SCORE_W-1:0] los_count,
  output logic               gameover,
  output logic [1:0]         who
);

  if (WIDTH < 1 || GAMEOVER_LIMIT < 1 || GAMEOVER_LIMIT > (2 ** SCORE_W) - 1) begin : g_bad_params
    $error("game_state_param: illegal WIDTH/SCORE_W/GAMEOVER_LIMIT combination");
  end

  mode_e            mode;
  logic [WIDTH-1:0] step_c;
  logic             up_c;
  logic             hold_c;
  logic [WIDTH-1:0] count_d;
  logic             advance_c;
  logic             win_c;
  logic             los_c;
  logic             win_hit;
  logic             los_hit;

  logic [WIDTH-1:0] count_q;
  logic             win_q;
  logic             los_q;
  logic             gameover_q;
  who_e             who_q;

  assign mode = mode_e'(control);

  // Mode decode: direction and step size; a step of 2 truncates to 0 when WIDTH = 1.
  always_comb begin
    step_c = '0;
    up_c   = 1'b1;
    hold_c = 1'b0;
    unique case (mode)
      UP1:     step_c = WIDTH'(1);
      UP2:     step_c = WIDTH'(2);
      DN1:     begin step_c = WIDTH'(1); up_c = 1'b0; end
      DN2:     begin step_c = WIDTH'(2); up_c = 1'b0; end
      UPS:     step_c = i_step;
      DNS:     begin step_c = i_step;    up_c = 1'b0; end
      default: hold_c = 1'b1;
    endcase
  end

  assign count_d   = up_c ? (count_q + step_c) : (count_q - step_c);
  assign advance_c = !INIT && !gameover_q && !hold_c;
  assign win_c     = advance_c && (count_d == '1);
  assign los_c     = advance_c && (count_d == '0);

  game_score_counter #(
    .SCORE_W        (SCORE_W),
    .GAMEOVER_LIMIT (GAMEOVER_LIMIT)
  ) u_win_score (
    .clk       (clk),
    .reset     (reset),
    .clr       (INIT),
    .inc       (win_c),
    .score     (win_count),
    .hit_limit (win_hit)
  );

  game_score_counter #(
    .SCORE_W        (SCORE_W),
    .GAMEOVER_LIMIT (GAMEOVER_LIMIT)
  ) u_los_score (
    .clk       (clk),
    .reset     (reset),
    .clr       (INIT),
    .inc       (los_c),
    .score     (los_count),
    .hit_limit (los_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      win_q      <= 1'b0;
      los_q      <= 1'b0;
      gameover_q <= 1'b0;
      who_q      <= WHO_NONE;
    end else if (INIT) begin
      count_q    <= i_value;
      win_q      <= 1'b0;
      los_q      <= 1'b0;
      gameover_q <= 1'b0;
      who_q      <= WHO_NONE;
    end else if (gameover_q || hold_c) begin
      win_q <= 1'b0;
      los_q <= 1'b0;
    end else begin
      count_q <= count_d;
      win_q   <= win_c;
      los_q   <= los_c;
      // win and los are mutually exclusive, so at most one hit fires per edge
      if (win_hit) begin
        gameover_q <= 1'b1;
        who_q      <= WHO_WINNER;
      end else if (los_hit) begin
        gameover_q <= 1'b1;
        who_q      <= WHO_LOSER;
      end
    end
  end

  assign count    = count_q;
  assign win      = win_q;
  assign los      = los_q;
  assign gameover = gameover_q;
  assign who      = who_q;

endmodule : game_state_param

// File: tb/tb_game_state_param.sv
// Directed scenarios plus random traffic against an arithmetic reference model of the game counter.
module tb_game_state_param;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned LIMIT = 15;
  localparam int MODV = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [2:0]         control;
  logic [WIDTH-1:0]   i_value;
  logic [WIDTH-1:0]   i_step;
  logic               INIT;
  logic [WIDTH-1:0]   count;
  logic               win;
  logic               los;
  logic [SCORE_W-1:0] win_count;
  logic [SCORE_W-1:0] los_count;
  logic               gameover;
  logic [1:0]         who;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_cnt, m_wc, m_lc, m_who;
  bit m_win, m_los, m_go;

  game_state_param #(.WIDTH(WIDTH), .SCORE_W(SCORE_W), .GAMEOVER_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .control   (control),
    .i_value   (i_value),
    .i_step    (i_step),
    .INIT      (INIT),
    .count     (count),
    .win       (win),
    .los       (los),
    .win_count (win_count),
    .los_count (los_count),
    .gameover  (gameover),
    .who       (who)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wc = 0; m_lc = 0; m_who = 0;
    m_win = 0; m_los = 0; m_go = 0;
  endtask

  // One clock edge of the game rules, using plain integer arithmetic.
  task automatic model_edge();
    int delta;
    if (INIT) begin
      m_cnt = int'(i_value);
      m_wc = 0; m_lc = 0; m_who = 0;
      m_win = 0; m_los = 0; m_go = 0;
    end else if (m_go || control >= 3'd6) begin
      m_win = 0; m_los = 0;
    end else begin
      case (control)
        3'd0: delta = 1;
        3'd1: delta = 2;
        3'd2: delta = -1;
        3'd3: delta = -2;
        3'd4: delta = int'(i_step);
        default: delta = -int'(i_step);
      endcase
      m_cnt = (((m_cnt + delta) % MODV) + MODV) % MODV;
      m_win = (m_cnt == MODV - 1);
      m_los = (m_cnt == 0);
      if (m_win) m_wc++;
      if (m_los) m_lc++;
      if (m_wc == int'(LIMIT)) begin m_go = 1; m_who = 2; end
      else if (m_lc == int'(LIMIT)) begin m_go = 1; m_who = 1; end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_cnt));
    chk({tag, ".win"}, 32'(win), 32'(m_win));
    chk({tag, ".los"}, 32'(los), 32'(m_los));
    chk({tag, ".win_count"}, 32'(win_count), 32'(m_wc));
    chk({tag, ".los_count"}, 32'(los_count), 32'(m_lc));
    chk({tag, ".gameover"}, 32'(gameover), 32'(m_go));
    chk({tag, ".who"}, 32'(who), 32'(m_who));
  endtask

  task automatic step_edge(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step_edge(tag);
  endtask

  task automatic start(input logic [2:0] ctl, input logic [WIDTH-1:0] val, input logic [WIDTH-1:0] stp);
    INIT = 1'b1; i_value = val; control = ctl; i_step = stp;
    step_edge("init");
    INIT = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".count"}, 32'(count), 0);
    chk({tag, ".flags"}, 32'({win, los, gameover}), 0);
    chk({tag, ".scores"}, 32'({win_count, los_count}), 0);
    chk({tag, ".who"}, 32'(who), 0);
  endtask

  initial begin
    reset = 1'b1; control = 3'd0; i_value = '0; i_step = '0; INIT = 1'b0;
    model_reset();
    #1;
    check_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_held");
    @(negedge clk);
    reset = 1'b0;

    // Up+1 from 0: winner at advance 239
    start(3'd0, 4'd0, 4'd0);
    run(238, "up1");
    chk("up1.pre_go", 32'(gameover), 0);
    run(1, "up1");
    chk("up1.go", 32'(gameover), 1);
    chk("up1.who", 32'(who), 2);
    chk("up1.wc", 32'(win_count), 15);
    chk("up1.lc", 32'(los_count), 14);
    run(5, "up1_frozen");

    // Down-1 from 1: loser at advance 225
    start(3'd2, 4'd1, 4'd0);
    run(225, "dn1");
    chk("dn1.who", 32'(who), 1);
    chk("dn1.lc", 32'(los_count), 15);
    chk("dn1.wc", 32'(win_count), 14);

    // Up+2 from 0: loser at advance 120, never wins
    start(3'd1, 4'd0, 4'd0);
    run(120, "up2");
    chk("up2.go", 32'(gameover), 1);
    chk("up2.who", 32'(who), 1);
    chk("up2.wc", 32'(win_count), 0);

    // Down-2 from 1: winner at advance 113
    start(3'd3, 4'd1, 4'd0);
    run(113, "dn2");
    chk("dn2.who", 32'(who), 2);
    chk("dn2.lc", 32'(los_count), 0);

    // INIT edge with all-ones value raises no flag; step 0 wins every edge
    start(3'd4, 4'd15, 4'd0);
    chk("ups0.init_win", 32'(win), 0);
    run(14, "ups0");
    chk("ups0.pre_go", 32'(gameover), 0);
    run(1, "ups0");
    chk("ups0.go", 32'(gameover), 1);
    chk("ups0.count", 32'(count), 15);
    start(3'd0, 4'd3, 4'd0);
    chk("restart.count", 32'(count), 3);
    chk("restart.go", 32'(gameover), 0);
    run(4, "restart");

    // Mid-game hold, then asynchronous reset between edges
    start(3'd0, 4'd0, 4'd0);
    run(20, "mid");
    control = 3'd6;
    run(5, "hold6");
    control = 3'd7;
    run(5, "hold7");
    chk("hold.count", 32'(count), 4);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_zero("mid_reset");
    #1;
    reset = 1'b0;
    control = 3'd0;
    step_edge("post_reset");
    chk("post_reset.count", 32'(count), 1);
    chk("post_reset.flag", 32'({win, los}), 0);

    // Random traffic with occasional INIT and asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      control = 3'($urandom_range(0, 7));
      i_step  = WIDTH'($urandom_range(0, 15));
      i_value = WIDTH'($urandom_range(0, 15));
      INIT    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_zero("rand_reset");
        #1;
        reset = 1'b0;
      end
      step_edge("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_game_state_param
